// File: rtl/gfx_pkg.sv
// Shared types and constants for the gfx arbitration blocks.
package gfx_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

  // Round-robin pointer sized for the largest supported requester count.
  localparam int unsigned RrNreqMax = 8;
  localparam int unsigned RrPtrW    = $clog2(RrNreqMax);

endpackage

// File: rtl/gfx_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after ptr_i, wrapping.
module gfx_rr_pick
  import gfx_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]      req_i,
  input  logic [RrPtrW-1:0] ptr_i,
  output logic [N-1:0]      gnt_o,
  output logic              valid_o
);

  localparam logic [N-1:0] One = N'(1);

  logic [N-1:0] mask;
  logic [N-1:0] hi;
  logic [N-1:0] pick;

  // Requests at or above the pointer win; otherwise wrap to the lowest set bit overall.
  assign mask    = ~((One << ptr_i) - One);
  assign hi      = req_i & mask;
  assign pick    = (hi != '0) ? hi : req_i;
  assign gnt_o   = pick & (~pick + One);
  assign valid_o = |req_i;

endmodule

// File: rtl/gfx256_wbm_arb.sv
// Round-robin arbiter with capped per-requester lock in front of the 256-bit Wishbone engine.
module gfx256_wbm_arb
  import gfx_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LOCK_MAX = 4,
  parameter int unsigned MDW      = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0]              we_i,
  input  logic [NREQ-1:0]              lock_i,
  input  logic [NREQ-1:0][31:0]        adr_i,
  input  logic [NREQ-1:0][MDW/8-1:0]   sel_i,
  input  logic [NREQ-1:0][MDW-1:0]     dat_i,
  output logic [NREQ-1:0]              ack_o,
  output logic [MDW-1:0]               dat_o,
  output logic [NREQ-1:0]              gnt_o,
  output logic                         read_request_o,
  output logic                         write_request_o,
  output logic [31:0]                  adr_o,
  output logic [MDW/8-1:0]             sel_o,
  output logic [MDW-1:0]               wdat_o,
  input  logic [MDW-1:0]               rdat_i,
  input  logic                         ack_i
);

  localparam int unsigned SW = MDW / 8;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [MDW-1:0]    dat_q, dat_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [MDW-1:0]    wdat_q, wdat_d;
  logic [RrPtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic [NREQ-1:0]   lock_own_q, lock_own_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;

  logic [NREQ-1:0]   rr_gnt;
  logic              rr_valid;
  logic              lock_hit;
  logic [NREQ-1:0]   win;
  logic              win_we;
  logic [31:0]       win_adr;
  logic [SW-1:0]     win_sel;
  logic [MDW-1:0]    win_dat;
  logic [RrPtrW-1:0] gnt_idx;
  logic [RrPtrW-1:0] nxt_ptr;

  gfx_rr_pick #(
    .N(NREQ)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (rr_gnt),
    .valid_o(rr_valid)
  );

  assign lock_hit = lock_q && ((lock_own_q & req_i) != '0);
  assign win      = lock_hit ? lock_own_q : rr_gnt;

  always_comb begin
    win_we  = 1'b0;
    win_adr = '0;
    win_sel = '0;
    win_dat = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (win[j]) begin
        win_we  = we_i[j];
        win_adr = adr_i[j];
        win_sel = sel_i[j];
        win_dat = dat_i[j];
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (gnt_q[j]) gnt_idx = RrPtrW'(j);
    end
  end

  assign nxt_ptr = (gnt_idx == RrPtrW'(NREQ - 1)) ? '0 : gnt_idx + RrPtrW'(1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    dat_d      = dat_q;
    busy_d     = busy_q;
    we_d       = we_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      StIdle: begin
        // An owner that dropped its request forfeits the lock.
        if (lock_q && !lock_hit) begin
          lock_d     = 1'b0;
          lock_cnt_d = '0;
        end
        if (rr_valid) begin
          state_d = StIssue;
          gnt_d   = win;
          busy_d  = 1'b1;
          we_d    = win_we;
          adr_d   = win_adr;
          sel_d   = win_sel;
          wdat_d  = win_dat;
        end
      end
      StIssue: begin
        if (ack_i) begin
          state_d = StRelease;
          ack_d   = gnt_q;
          dat_d   = rdat_i;
          busy_d  = 1'b0;
          if (((lock_i & gnt_q) != '0) && (lock_cnt_q < CW'(LOCK_MAX - 1))) begin
            lock_d     = 1'b1;
            lock_own_d = gnt_q;
            lock_cnt_d = lock_cnt_q + CW'(1);
          end else begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
            rr_ptr_d   = nxt_ptr;
          end
        end
      end
      StRelease: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      ack_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      wdat_q     <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_own_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      wdat_q     <= wdat_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign ack_o           = ack_q;
  assign dat_o           = dat_q;
  assign read_request_o  = busy_q & ~we_q;
  assign write_request_o = busy_q & we_q;
  assign adr_o           = adr_q;
  assign sel_o           = sel_q;
  assign wdat_o          = wdat_q;

endmodule

// File: tb/tb_gfx256_wbm_arb.sv
// Bench for gfx256_wbm_arb: vector table, lock/reset/stray-ack sequences, randomized queues.
module tb_gfx256_wbm_arb;

  localparam int NREQ     = 4;
  localparam int LOCK_MAX = 4;
  localparam int MDW      = 256;
  localparam int SW       = MDW / 8;

  typedef struct {
    bit              we;
    bit              lock;
    logic [31:0]     adr;
    logic [SW-1:0]   sel;
    logic [MDW-1:0]  dat;
  } txn_t;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] we;
    logic [NREQ-1:0] exp_gnt;
  } vec_t;

  logic                       clk;
  logic                       rst;
  logic [NREQ-1:0]            req_i, we_i, lock_i;
  logic [NREQ-1:0][31:0]      adr_i;
  logic [NREQ-1:0][SW-1:0]    sel_i;
  logic [NREQ-1:0][MDW-1:0]   dat_i;
  logic [NREQ-1:0]            ack_o;
  logic [MDW-1:0]             dat_o;
  logic [NREQ-1:0]            gnt_o;
  logic                       read_request_o, write_request_o;
  logic [31:0]                adr_o;
  logic [SW-1:0]              sel_o;
  logic [MDW-1:0]             wdat_o;
  logic [MDW-1:0]             rdat_i;
  logic                       ack_i;

  int   checks   = 0;
  int   failures = 0;
  bit   eng_en   = 1'b1;
  bit   stray_req = 1'b0;
  bit   eng_we   = 1'b0;
  int   eng_cnt  = 0;
  int   m_ptr    = 0;
  txn_t q[NREQ][$];
  int   exp_q[$];
  vec_t vecs[8];

  gfx256_wbm_arb #(
    .NREQ    (NREQ),
    .LOCK_MAX(LOCK_MAX),
    .MDW     (MDW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req_i),
    .we_i           (we_i),
    .lock_i         (lock_i),
    .adr_i          (adr_i),
    .sel_i          (sel_i),
    .dat_i          (dat_i),
    .ack_o          (ack_o),
    .dat_o          (dat_o),
    .gnt_o          (gnt_o),
    .read_request_o (read_request_o),
    .write_request_o(write_request_o),
    .adr_o          (adr_o),
    .sel_o          (sel_o),
    .wdat_o         (wdat_o),
    .rdat_i         (rdat_i),
    .ack_i          (ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [MDW-1:0] rdat_of(input logic [31:0] a);
    if (a == 32'h1000) return {(MDW / 8){8'hA5}};
    return {(MDW / 32){a ^ 32'h3C5A_96E1}};
  endfunction

  // Engine model: acks on the third negedge after a request is seen.
  initial begin
    ack_i  = 1'b0;
    rdat_i = '0;
    forever begin
      @(negedge clk);
      if (!eng_en || rst) begin
        eng_cnt   = 0;
        ack_i     = stray_req;
        stray_req = 1'b0;
      end else if ((read_request_o || write_request_o) && !ack_i) begin
        eng_cnt++;
        if (eng_cnt == 3) begin
          ack_i   = 1'b1;
          rdat_i  = rdat_of(adr_o);
          eng_we  = write_request_o;
          eng_cnt = 0;
        end
      end else begin
        ack_i = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [MDW-1:0] got, input logic [MDW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ack_o != '0) ok = 1'b1;
      else @(negedge clk);
    end
    check("ack_seen", {255'b0, ok}, 256'd1);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_i  = '0;
    we_i   = '0;
    lock_i = '0;
    eng_en = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  // One isolated transaction; the winner is given by the caller.
  task automatic apply_vec(input logic [NREQ-1:0] req, input logic [NREQ-1:0] we,
                           input logic [NREQ-1:0] exp_gnt);
    int w;
    bit ok;
    w = 0;
    for (int r = 0; r < NREQ; r++) if (exp_gnt[r]) w = r;
    @(negedge clk);
    req_i  = req;
    we_i   = we;
    lock_i = '0;
    for (int r = 0; r < NREQ; r++) begin
      adr_i[r] = 32'(32'h1000 * (r + 1));
      sel_i[r] = {SW{1'b1}} >> r;
      dat_i[r] = {(MDW / 32){32'hD000_0000 | 32'(r)}};
    end
    @(negedge clk);
    check("vec_gnt", gnt_o, exp_gnt);
    check("vec_adr", adr_o, 32'(32'h1000 * (w + 1)));
    check("vec_sel", sel_o, {SW{1'b1}} >> w);
    check("vec_rd", read_request_o, !we[w]);
    check("vec_wr", write_request_o, we[w]);
    if (we[w]) check("vec_wdat", wdat_o, {(MDW / 32){32'hD000_0000 | 32'(w)}});
    wait_ack(ok);
    if (ok) begin
      check("vec_ack", ack_o, exp_gnt);
      check("vec_dat", dat_o, rdat_of(32'(32'h1000 * (w + 1))));
    end
    req_i = '0;
    @(negedge clk);
    check("vec_gnt_clr", gnt_o, '0);
    check("vec_ack_clr", ack_o, '0);
    m_ptr = (w + 1) % NREQ;
  endtask

  // Transaction-level reference: grant order implied by the lock and round-robin rules.
  function automatic void model_order();
    int pos[NREQ];
    bit lk;
    bit any;
    int own, cnt, g;
    lk  = 1'b0;
    own = 0;
    cnt = 0;
    for (int r = 0; r < NREQ; r++) pos[r] = 0;
    exp_q.delete();
    while (1) begin
      any = 1'b0;
      for (int r = 0; r < NREQ; r++) if (pos[r] < q[r].size()) any = 1'b1;
      if (!any) break;
      if (lk && pos[own] < q[own].size()) begin
        g = own;
      end else begin
        lk  = 1'b0;
        cnt = 0;
        g   = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && pos[(m_ptr + k) % NREQ] < q[(m_ptr + k) % NREQ].size())
            g = (m_ptr + k) % NREQ;
        end
      end
      exp_q.push_back(g);
      if (q[g][pos[g]].lock && cnt < LOCK_MAX - 1) begin
        lk  = 1'b1;
        own = g;
        cnt++;
      end else begin
        lk    = 1'b0;
        cnt   = 0;
        m_ptr = (g + 1) % NREQ;
      end
      pos[g]++;
    end
  endfunction

  task automatic drive_reqs();
    for (int r = 0; r < NREQ; r++) begin
      if (q[r].size() > 0) begin
        req_i[r]  = 1'b1;
        we_i[r]   = q[r][0].we;
        lock_i[r] = q[r][0].lock;
        adr_i[r]  = q[r][0].adr;
        sel_i[r]  = q[r][0].sel;
        dat_i[r]  = q[r][0].dat;
      end else begin
        req_i[r]  = 1'b0;
        lock_i[r] = 1'b0;
      end
    end
  endtask

  task automatic run_queues(input string tag);
    int              g;
    int              budget;
    txn_t            t;
    logic [NREQ-1:0] oh;
    model_order();
    budget = 0;
    while (exp_q.size() > 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (ack_o != '0) begin
        g     = exp_q.pop_front();
        t     = q[g][0];
        oh    = '0;
        oh[g] = 1'b1;
        check({tag, "_owner"}, ack_o, oh);
        check({tag, "_adr"}, adr_o, t.adr);
        check({tag, "_sel"}, sel_o, t.sel);
        check({tag, "_we"}, eng_we, t.we);
        check({tag, "_dat"}, dat_o, rdat_of(t.adr));
        if (t.we) check({tag, "_wdat"}, wdat_o, t.dat);
        void'(q[g].pop_front());
      end
      drive_reqs();
    end
    check({tag, "_left"}, exp_q.size(), 0);
    for (int r = 0; r < NREQ; r++) q[r].delete();
    drive_reqs();
    repeat (3) @(negedge clk);
  endtask

  function automatic txn_t mk(input bit we, input bit lock, input logic [31:0] adr);
    txn_t t;
    t.we   = we;
    t.lock = lock;
    t.adr  = adr;
    t.sel  = {SW{1'b1}};
    t.dat  = {(MDW / 32){~adr}};
    return t;
  endfunction

  initial begin
    txn_t t;
    vecs[0] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[1] = '{4'b1001, 4'b1000, 4'b1000};
    vecs[2] = '{4'b0110, 4'b0010, 4'b0010};
    vecs[3] = '{4'b0011, 4'b0000, 4'b0001};
    vecs[4] = '{4'b1100, 4'b0100, 4'b0100};
    vecs[5] = '{4'b1010, 4'b1111, 4'b1000};
    vecs[6] = '{4'b0100, 4'b0000, 4'b0100};
    vecs[7] = '{4'b0111, 4'b0001, 4'b0001};
    adr_i = '0;
    sel_i = '0;
    dat_i = '0;

    do_reset();
    check("rst_gnt", gnt_o, '0);
    check("rst_ack", ack_o, '0);
    check("rst_dat", dat_o, '0);
    check("rst_rd", read_request_o, 1'b0);
    check("rst_wr", write_request_o, 1'b0);
    check("rst_adr", adr_o, '0);
    check("rst_sel", sel_o, '0);
    check("rst_wdat", wdat_o, '0);

    foreach (vecs[i]) apply_vec(vecs[i].req, vecs[i].we, vecs[i].exp_gnt);

    // Stray ack in IDLE must be ignored and leave the pointer where it was.
    eng_en    = 1'b0;
    stray_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stray_ack", ack_o, '0);
      check("stray_gnt", gnt_o, '0);
      check("stray_req", {read_request_o, write_request_o}, 2'b00);
    end
    eng_en = 1'b1;
    apply_vec(4'b1010, 4'b0000, 4'b0010);

    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      q[r].push_back(mk(1'b0, 1'b0, 32'(32'h4000 + r * 16)));
      q[r].push_back(mk(1'b0, 1'b0, 32'(32'h5000 + r * 16)));
    end
    run_queues("contend");

    do_reset();
    apply_vec(4'b0010, 4'b0000, 4'b0010);
    q[2].push_back(mk(1'b0, 1'b1, 32'h2000));
    q[2].push_back(mk(1'b1, 1'b0, 32'h2000));
    q[0].push_back(mk(1'b0, 1'b0, 32'h3000));
    q[0].push_back(mk(1'b0, 1'b0, 32'h3004));
    run_queues("rmw");

    do_reset();
    for (int k = 0; k < 5; k++) q[1].push_back(mk(1'b0, 1'b1, 32'(32'h6000 + k * 4)));
    q[3].push_back(mk(1'b1, 1'b0, 32'h7000));
    q[3].push_back(mk(1'b0, 1'b0, 32'h7004));
    run_queues("lockcap");

    // Reset one cycle into a transaction.
    apply_vec(4'b0100, 4'b0000, 4'b0100);
    eng_en = 1'b0;
    @(negedge clk);
    req_i = 4'b0010;
    we_i  = '0;
    @(negedge clk);
    check("mid_gnt", gnt_o, 4'b0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", gnt_o, '0);
    check("mid_rst_rd", read_request_o, 1'b0);
    check("mid_rst_adr", adr_o, '0);
    check("mid_rst_dat", dat_o, '0);
    check("mid_rst_ack", ack_o, '0);
    req_i = '0;
    @(negedge clk);
    rst    = 1'b0;
    eng_en = 1'b1;
    m_ptr  = 0;
    apply_vec(4'b1001, 4'b0000, 4'b0001);
    apply_vec(4'b0100, 4'b0000, 4'b0100);

    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < NREQ; r++) begin
        int n;
        n = $urandom_range(0, 5);
        for (int k = 0; k < n; k++) begin
          t.we   = 1'($urandom_range(0, 1));
          t.lock = ($urandom_range(0, 2) == 0);
          t.adr  = $urandom;
          t.sel  = $urandom;
          for (int b = 0; b < MDW / 32; b++) t.dat[b*32 +: 32] = $urandom;
          q[r].push_back(t);
        end
      end
      run_queues("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gfx256_wbm_arb.md
# gfx256_wbm_arb

Round-robin arbiter that shares the single 256-bit Wishbone read/write engine (`gfx256_wbm_rw`) among NREQ graphics requesters, e.g. texture fetch, pixel write, Z-buffer and blitter. It latches one winner's request, drives the engine's request/address/select/data inputs until the engine acknowledges, then routes the returned data and a one-cycle ack back to that winner. A per-requester lock lets a read-modify-write pair stay atomic. A lock cap prevents starvation.

## Interface
- NREQ, 4: number of requesters, 2..8.
- LOCK_MAX, 4: maximum back-to-back grants to one locked requester. Must be at least 1.
- MDW, 256: data width. Select width is MDW/8.

- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  NREQ  per-requester request level, held until ack_o.
- we_i  in  NREQ  1 = write.
- lock_i  in  NREQ  keep the grant after this transaction.
- adr_i  in  NREQ×32  byte address.
- sel_i  in  NREQ×MDW/8  byte lanes.
- dat_i  in  NREQ×MDW  write data.
- ack_o  out  NREQ  one-cycle completion pulse, one-hot.
- dat_o  out  MDW  read data, broadcast, valid with ack_o.
- gnt_o  out  NREQ  one-hot current owner, 0 when idle.
- read_request_o  out  1  to the engine's read_request_i.
- write_request_o  out  1  to the engine's write_request_i.
- adr_o  out  32  to the engine's texture_addr_i.
- sel_o  out  MDW/8  to the engine's texture_sel_i.
- wdat_o  out  MDW  to the engine's texture_dat_i.
- rdat_i  in  MDW  from the engine's texture_dat_o.
- ack_i  in  1  from the engine's texture_data_ack.

## Operation
- The arbiter is a three-state machine with states IDLE, ISSUE and RELEASE, held in `arb_state_e`.
- IDLE:
  - If any req_i bit is set, pick a winner g and go to ISSUE.
  - If the lock is active, g is the lock owner, provided its req_i is still set.
  - Otherwise g is the round-robin pick: the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Latch g into gnt_o.
  - Latch we_i[g], adr_i[g], sel_i[g] and dat_i[g] into registers. The outputs are driven from these registers, not from the live inputs.
  - Drive read_request_o = !we and write_request_o = we.
- ISSUE:
  - Hold all outputs stable.
  - When ack_i is seen: register ack_o[g]=1 and dat_o=rdat_i, clear both request outputs, go to RELEASE.
- RELEASE, one cycle:
  - ack_o returns to 0 and gnt_o is cleared.
  - Go to IDLE. This gives the requester one cycle to drop or update req_i before it is sampled again.
- Lock rules, evaluated on the ack cycle:
  - If lock_i[g]=1 and `lock_cnt` < LOCK_MAX-1: lock owner = g and `lock_cnt` increments.
  - Otherwise: clear the lock, reset `lock_cnt` to 0, and set `rr_ptr` = (g+1) mod NREQ.
  - If the lock owner's req_i is low in IDLE, clear the lock and arbitrate normally.
- `rr_ptr` is not advanced while a lock is held.
- Because of the engine's own delay state, there is never more than one outstanding transaction.

## Timing
- Reset values:
  - All outputs are 0: ack_o, dat_o, gnt_o, both request outputs, adr_o, sel_o and wdat_o.
  - State is IDLE, `rr_ptr`=0, lock cleared, `lock_cnt`=0.
- Reset asserted mid-transaction: the arbiter returns to IDLE asynchronously. The engine shares rst_i, so there is nothing to drain.
- The arbiter reacts to ack_i only in ISSUE. A stray ack_i in IDLE or RELEASE is ignored and no ack_o is generated.
- Cycle sequence for one transaction:
  - Cycle 0: req_i is sampled in IDLE.
  - Edge 1: request outputs and gnt_o are registered high.
  - ack_i arrives at cycle k, where k is engine latency; the minimum is cycle 2.
  - Edge k+1: ack_o and dat_o are valid, state is RELEASE.
  - Edge k+2: state is IDLE.
  - Edge k+3: earliest next grant.
- Request-to-ack latency is engine latency + 1 cycle. Minimum back-to-back spacing is 3 cycles beyond the engine's ack.
- Simultaneous requests: exactly one is granted per IDLE cycle.
- A request from the current owner arriving while the arbiter is in RELEASE is not granted until IDLE.

## Structure
- Add to `gfx_pkg`:
  - `arb_state_e`: 2-bit enum with IDLE=0, ISSUE=1, RELEASE=2.
  - A clog2 helper constant for `rr_ptr` width.
- Sub-module `gfx_rr_pick`: combinational rotate-priority encoder.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and a valid flag.
  - Reusable by other gfx arbiters.
- The arbiter instantiates alongside `gfx256_wbm_rw`. The arbiter's request/address/select/data outputs connect to the engine's inputs; rdat_i and ack_i connect from the engine's outputs.

## Test plan
Engine model acks 3 cycles after a request is seen.
- Single read: req_i=0001, adr_i[0]=0x1000, engine returns rdat=0xA5…A5 -> adr_o=0x1000, read_request_o=1, one pulse of ack_o=0001 with dat_o=0xA5…A5, then gnt_o=0.
- Contention: req_i=1111 held continuously -> grants occur in order 0,1,2,3,0; each requester gets exactly one ack_o pulse per round.
- Lock RMW: requester 2 reads 0x2000 with lock_i=1, then writes 0x2000 with lock_i=0, while requester 0 requests throughout -> the sequence is read(2), write(2), then grant 0.
- Lock cap: requester 1 holds req_i=1 and lock_i=1 continuously, requester 3 also requests, LOCK_MAX=4 -> four consecutive grants to 1, then a grant to 3.
- Stray ack: pulse ack_i while in IDLE -> no ack_o, no state change.
- Reset mid-ISSUE: assert rst_i 1 cycle after grant -> all outputs 0 immediately, `rr_ptr`=0, the next req_i=0100 is granted normally.
